// File: rtl/sar_sequencer.sv
// Successive-approximation sequencer for a 6-bit SAR ADC.
// Generates the sample pulse and the active-low bit strobes d6b..d1b, MSB
// first. It drives the DAC trial code and accumulates the result of the
// binary search.
module sar_sequencer #(
   parameter int unsigned SAMPLE_CYCLES = 4,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       comp_in,
   output logic       sample,
   output logic       d6b,
   output logic       d5b,
   output logic       d4b,
   output logic       d3b,
   output logic       d2b,
   output logic       d1b,
   output logic [5:0] dac_code,
   output logic [5:0] result,
   output logic       busy,
   output logic       done
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SAMPLE = 3'd1;
   localparam logic [2:0] ST_SETTLE = 3'd2;
   localparam logic [2:0] ST_STROBE = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   localparam logic [7:0] SAMPLE_LOAD = 8'(SAMPLE_CYCLES - 1);
   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

   logic [2:0] state;
   logic [2:0] nxt_state;
   logic [2:0] bit_idx;
   logic [2:0] nxt_idx;
   logic [7:0] cnt;
   logic [7:0] nxt_cnt;
   logic [5:0] nxt_code;
   logic [5:0] nxt_result;
   logic [5:0] mask;
   logic [5:0] trial;
   logic [5:0] strb;

   assign d6b = strb[5];
   assign d5b = strb[4];
   assign d4b = strb[3];
   assign d3b = strb[2];
   assign d2b = strb[1];
   assign d1b = strb[0];

   // Next-state logic. The registered outputs are derived from the next
   // state, so each output is valid in the same cycle as the state it belongs to.
   always_comb begin
      nxt_state  = state;
      nxt_idx    = bit_idx;
      nxt_cnt    = cnt;
      nxt_code   = dac_code;
      nxt_result = result;
      mask       = 6'b000001 << bit_idx;
      trial      = comp_in ? dac_code : (dac_code & ~mask);
      case (state)
         ST_IDLE: begin
            if (start) begin
               nxt_state = ST_SAMPLE;
               nxt_cnt   = SAMPLE_LOAD;
               nxt_code  = '0;
               nxt_idx   = 3'd5;
            end
         end
         ST_SAMPLE: begin
            if (cnt == 8'd0) begin
               nxt_state = ST_SETTLE;
               nxt_cnt   = SETTLE_LOAD;
               nxt_code  = 6'b100000;
               nxt_idx   = 3'd5;
            end else begin
               nxt_cnt = cnt - 8'd1;
            end
         end
         ST_SETTLE: begin
            if (cnt == 8'd0) begin
               nxt_state = ST_STROBE;
            end else begin
               nxt_cnt = cnt - 8'd1;
            end
         end
         ST_STROBE: begin
            if (bit_idx != 3'd0) begin
               nxt_code  = trial | (mask >> 1);
               nxt_idx   = bit_idx - 3'd1;
               nxt_cnt   = SETTLE_LOAD;
               nxt_state = ST_SETTLE;
            end else begin
               nxt_code   = trial;
               nxt_result = trial;
               nxt_state  = ST_DONE;
            end
         end
         ST_DONE: begin
            nxt_state = ST_IDLE;
            nxt_code  = '0;
         end
         default: begin
            nxt_state = ST_IDLE;
            nxt_code  = '0;
         end
      endcase
   end

   // State and registered outputs, with an asynchronous abort to reset values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         bit_idx  <= 3'd5;
         cnt      <= '0;
         dac_code <= '0;
         result   <= '0;
         sample   <= 1'b0;
         strb     <= '1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= nxt_state;
         bit_idx  <= nxt_idx;
         cnt      <= nxt_cnt;
         dac_code <= nxt_code;
         result   <= nxt_result;
         sample   <= (nxt_state == ST_SAMPLE);
         strb     <= (nxt_state == ST_STROBE) ? ~(6'b000001 << nxt_idx) : '1;
         busy     <= (nxt_state != ST_IDLE);
         done     <= (nxt_state == ST_DONE);
      end
   end

endmodule

// File: tb/tb_sar_sequencer.sv
// Directed testbench for sar_sequencer. It checks a default-parameter
// instance and a fast instance (SAMPLE_CYCLES=1, SETTLE_CYCLES=1).
module tb_sar_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, start_f;
   logic [5:0] vin, vin_f;
   logic       comp_in, comp_in_f;

   logic       sample, d6b, d5b, d4b, d3b, d2b, d1b, busy, done;
   logic [5:0] dac_code, result;
   logic       sample_f, d6b_f, d5b_f, d4b_f, d3b_f, d2b_f, d1b_f, busy_f, done_f;
   logic [5:0] dac_code_f, result_f;
   logic [5:0] strb, strb_f;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // Ideal comparator: 1 when Vin >= Vdac.
   assign comp_in   = (vin >= dac_code);
   assign comp_in_f = (vin_f >= dac_code_f);
   assign strb      = {d6b, d5b, d4b, d3b, d2b, d1b};
   assign strb_f    = {d6b_f, d5b_f, d4b_f, d3b_f, d2b_f, d1b_f};

   sar_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .comp_in(comp_in),
      .sample(sample), .d6b(d6b), .d5b(d5b), .d4b(d4b), .d3b(d3b),
      .d2b(d2b), .d1b(d1b), .dac_code(dac_code), .result(result),
      .busy(busy), .done(done)
   );

   sar_sequencer #(.SAMPLE_CYCLES(1), .SETTLE_CYCLES(1)) dut_fast (
      .clk(clk), .rst_n(rst_n), .start(start_f), .comp_in(comp_in_f),
      .sample(sample_f), .d6b(d6b_f), .d5b(d5b_f), .d4b(d4b_f), .d3b(d3b_f),
      .d2b(d2b_f), .d1b(d1b_f), .dac_code(dac_code_f), .result(result_f),
      .busy(busy_f), .done(done_f)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One default-parameter conversion. Cycle c is observed 1 time unit after
   // edge c-1, where edge 0 is the edge that samples start.
   task automatic run_conv(input string name, input logic [5:0] v,
                           input logic [35:0] exp_trials, input logic [5:0] prev_res,
                           input bit pulse_start);
      int strb_cyc[6];
      int strb_cnt[6];
      logic [5:0] trial[6];
      int done_cyc, done_cnt, samp_cnt, samp_bad, multi, res_bad, busy_bad, lows;
      logic [5:0] exp_res;
      done_cyc = -1; done_cnt = 0; samp_cnt = 0; samp_bad = 0;
      multi = 0; res_bad = 0; busy_bad = 0;
      for (int k = 0; k < 6; k++) begin
         strb_cyc[k] = -1; strb_cnt[k] = 0; trial[k] = '0;
      end
      vin = v;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         start = pulse_start && (c == 5 || c == 15);
         if (sample) begin
            samp_cnt++;
            if (c > 4) samp_bad++;
         end
         lows = 0;
         for (int k = 0; k < 6; k++) begin
            if (!strb[k]) begin
               lows++;
               strb_cnt[k]++;
               strb_cyc[k] = c;
               trial[k] = dac_code;
            end
         end
         if (lows > 1 || (lows > 0 && sample)) multi++;
         if (done) begin
            done_cnt++;
            done_cyc = c;
         end
         exp_res = (c < 23) ? prev_res : v;
         if (result !== exp_res) res_bad++;
         if ((c <= 23) !== (busy === 1'b1)) busy_bad++;
         step();
      end
      start = 1'b0;

      tests++;
      if (samp_cnt != 4 || samp_bad != 0) begin
         fails++;
         $display("FAIL %s sample_len: got %0d cycles (%0d late), expected 4", name, samp_cnt, samp_bad);
      end
      for (int k = 5; k >= 0; k--) begin
         tests++;
         if (strb_cnt[k] != 1 || strb_cyc[k] != 4 + (5 - k) * 3 + 3) begin
            fails++;
            $display("FAIL %s strobe_bit%0d: got %0d lows last at cycle %0d, expected 1 at cycle %0d",
                     name, k, strb_cnt[k], strb_cyc[k], 4 + (5 - k) * 3 + 3);
         end
         tests++;
         if (trial[k] !== exp_trials[6*k +: 6]) begin
            fails++;
            $display("FAIL %s trial_bit%0d: got %h expected %h", name, k, trial[k], exp_trials[6*k +: 6]);
         end
      end
      tests++;
      if (multi != 0) begin
         fails++;
         $display("FAIL %s strobe_exclusive: got %0d bad cycles, expected 0", name, multi);
      end
      tests++;
      if (done_cnt != 1 || done_cyc != 23) begin
         fails++;
         $display("FAIL %s done_timing: got %0d pulses last at cycle %0d, expected 1 at cycle 23",
                  name, done_cnt, done_cyc);
      end
      tests++;
      if (res_bad != 0 || result !== v) begin
         fails++;
         $display("FAIL %s result: got %h (%0d unstable cycles), expected %h", name, result, res_bad, v);
      end
      tests++;
      if (busy_bad != 0) begin
         fails++;
         $display("FAIL %s busy_window: got %0d bad cycles, expected 0", name, busy_bad);
      end
      tests++;
      if (dac_code !== 6'h00) begin
         fails++;
         $display("FAIL %s dac_idle: got %h expected 00", name, dac_code);
      end
   endtask

   task automatic test_reset();
      int bad_done, bad_strb;
      bad_done = 0; bad_strb = 0;
      rst_n = 1'b0; start = 1'b0; start_f = 1'b0; vin = '0; vin_f = '0;
      step();
      step();
      #2 rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         if (done !== 1'b0) bad_done++;
         if (strb !== 6'h3F) bad_strb++;
      end
      tests++;
      if ({sample, busy, done, dac_code, result} !== 15'h0) begin
         fails++;
         $display("FAIL reset_outputs: got sample=%b busy=%b done=%b dac=%h result=%h, expected all 0",
                  sample, busy, done, dac_code, result);
      end
      tests++;
      if (bad_strb != 0) begin
         fails++;
         $display("FAIL reset_strobes: got %0d cycles with a low strobe, expected 0", bad_strb);
      end
      tests++;
      if (bad_done != 0) begin
         fails++;
         $display("FAIL reset_done: got %0d done pulses, expected 0", bad_done);
      end
   endtask

   task automatic test_conversion();
      run_conv("conv_2b", 6'h2B, {6'h20, 6'h30, 6'h28, 6'h2C, 6'h2A, 6'h2B}, 6'h00, 1'b0);
   endtask

   task automatic test_edge_codes();
      run_conv("conv_00", 6'h00, {6'h20, 6'h10, 6'h08, 6'h04, 6'h02, 6'h01}, 6'h2B, 1'b0);
      run_conv("conv_3f", 6'h3F, {6'h20, 6'h30, 6'h38, 6'h3C, 6'h3E, 6'h3F}, 6'h00, 1'b0);
   endtask

   task automatic test_start_ignored();
      run_conv("start_ignored", 6'h15, {6'h20, 6'h10, 6'h18, 6'h14, 6'h16, 6'h15}, 6'h3F, 1'b1);
   endtask

   task automatic test_reset_abort();
      int bad;
      bad = 0;
      vin = 6'h2B;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c < 12; c++) step();
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL abort_busy_before: got %b expected 1", busy);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({sample, busy, done, dac_code, result, strb} !== {15'h0, 6'h3F}) begin
         fails++;
         $display("FAIL abort_async: got sample=%b busy=%b done=%b dac=%h result=%h strb=%b, expected 0,0,0,00,00,111111",
                  sample, busy, done, dac_code, result, strb);
      end
      step();
      if (strb !== 6'h3F) bad++;
      step();
      if (strb !== 6'h3F) bad++;
      #2 rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         if (strb !== 6'h3F || busy !== 1'b0) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL abort_quiet: got %0d cycles with strobe or busy active, expected 0", bad);
      end
      run_conv("abort_recover", 6'h2B, {6'h20, 6'h30, 6'h28, 6'h2C, 6'h2A, 6'h2B}, 6'h00, 1'b0);
   endtask

   task automatic test_back_to_back();
      int dcyc[3];
      int scyc[3];
      int dn, sn, lows, res_bad;
      dn = 0; sn = 0; lows = 0; res_bad = 0;
      for (int i = 0; i < 3; i++) begin
         dcyc[i] = -1; scyc[i] = -1;
      end
      vin_f = 6'h15;
      start_f = 1'b1;
      step();
      for (int c = 1; c <= 45; c++) begin
         if (done_f) begin
            if (dn < 3) dcyc[dn] = c;
            dn++;
            if (result_f !== 6'h15) res_bad++;
         end
         if (sample_f) begin
            if (sn < 3) scyc[sn] = c;
            sn++;
         end
         for (int k = 0; k < 6; k++) if (!strb_f[k]) lows++;
         step();
      end
      start_f = 1'b0;
      tests++;
      if (dn != 3 || dcyc[0] != 14 || dcyc[1] != 29 || dcyc[2] != 44) begin
         fails++;
         $display("FAIL b2b_done: got %0d pulses at %0d,%0d,%0d, expected 3 at 14,29,44",
                  dn, dcyc[0], dcyc[1], dcyc[2]);
      end
      tests++;
      if (sn != 3 || scyc[0] != 1 || scyc[1] != 16 || scyc[2] != 31) begin
         fails++;
         $display("FAIL b2b_sample: got %0d cycles at %0d,%0d,%0d, expected 3 at 1,16,31",
                  sn, scyc[0], scyc[1], scyc[2]);
      end
      tests++;
      if (lows != 18) begin
         fails++;
         $display("FAIL b2b_strobes: got %0d strobe lows, expected 18", lows);
      end
      tests++;
      if (res_bad != 0) begin
         fails++;
         $display("FAIL b2b_result: got %0d wrong results at done, expected 0", res_bad);
      end
   endtask

   initial begin
      test_reset();
      test_conversion();
      test_edge_codes();
      test_start_ignored();
      test_reset_abort();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
